// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out handshake bundle with flush
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst_code;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm_out;
    logic [2:0]      imm_fmt;
    logic            imm_illegal;

    modport master (
        output flush, in_valid, inst_code, out_ready,
        input  in_ready, out_valid, imm_out, imm_fmt, imm_illegal
    );

    modport slave (
        input  flush, in_valid, inst_code, out_ready,
        output in_ready, out_valid, imm_out, imm_fmt, imm_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32/RV64 immediate decoder with skid buffer and flush
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input logic clk,
    input logic rst_n,
    imm_gen_pipe_if.slave bus
);
    localparam int W = XLEN + 4;
    localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                           F_U = 3'd4, F_J = 3'd5, F_SH = 3'd6;

    logic [31:0]        inst;
    logic [2:0]         f3, fmt;
    logic               ill;
    logic [5:0]         sh;
    logic signed [31:0] sv;
    logic [XLEN-1:0]    imm;
    logic [W-1:0]       dec, out_q, skid_q;
    logic               out_v, skid_full, acc, out_free;

    assign inst = bus.inst_code;
    assign f3 = inst[14:12];

    // classify the opcode into an immediate format and legality
    always_comb begin
        fmt = F_NONE;
        ill = 1'b0;
        sh = {1'b0, inst[24:20]};
        if (inst[1:0] != 2'b11) ill = 1'b1;
        else case (inst[6:0])
            7'b0000011, 7'b1100111: fmt = F_I;
            7'b0010011: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    fmt = F_SH;
                    if (XLEN == 64) sh = inst[25:20];
                    else ill = inst[25];
                end else fmt = F_I;
            end
            7'b0100011: fmt = F_S;
            7'b1100011: fmt = F_B;
            7'b1101111: fmt = F_J;
            7'b0110111, 7'b0010111: fmt = F_U;
            7'b0011011: begin
                if (XLEN != 64) ill = 1'b1;
                else if (f3 == 3'b000) fmt = F_I;
                else if (f3 == 3'b001 || f3 == 3'b101) begin
                    fmt = F_SH;
                    ill = inst[25];
                end else ill = 1'b1;
            end
            7'b0110011, 7'b0001111, 7'b1110011: ill = 1'b0;
            7'b0111011: ill = (XLEN != 64);
            default: ill = 1'b1;
        endcase
    end

    assign sv = fmt == F_I ? {{20{inst[31]}}, inst[31:20]} :
                fmt == F_S ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                fmt == F_B ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                fmt == F_J ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
                fmt == F_U ? {inst[31:12], 12'b0} : 32'sd0;
    assign imm = fmt == F_SH ? XLEN'(sh) : XLEN'(sv);
    assign dec = {ill, fmt, imm};

    assign out_free = !out_v || bus.out_ready;
    assign bus.in_ready = rst_n && !bus.flush && ((SKID != 0) ? !skid_full : out_free);
    assign acc = bus.in_valid && bus.in_ready;

    // output register fed from the skid entry first so order is kept; stalled accepts park in skid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_v <= 1'b0;
            skid_full <= 1'b0;
            out_q <= '0;
            skid_q <= '0;
        end else if (bus.flush) begin
            out_v <= 1'b0;
            skid_full <= 1'b0;
        end else if (out_free) begin
            out_v <= skid_full || acc;
            skid_full <= 1'b0;
            if (skid_full) out_q <= skid_q;
            else if (acc) out_q <= dec;
        end else if (acc) begin
            skid_q <= dec;
            skid_full <= 1'b1;
        end
    end

    assign bus.out_valid = out_v;
    assign {bus.imm_illegal, bus.imm_fmt, bus.imm_out} = out_q;
endmodule
